// File: rtl/dsk_track_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsk_pkg
// Brief    : Shared disk-slot constants and prefetcher state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dsk_pkg;

    localparam logic [1:0]  DSK_SLOT_INT = 2'd0;
    localparam logic [1:0]  DSK_SLOT_EXT = 2'd1;

    localparam logic [21:0] DSK_INT_BASE = 22'h100000;
    localparam logic [21:0] DSK_EXT_BASE = 22'h200000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dskState_t;

endpackage : dsk_pkg
`default_nettype wire

// File: rtl/dsk_track_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : dsk_track_prefetch_if
// Brief    : Track control, RAM slot and byte-stream signals of one prefetcher.
// Revision : 1.0 - initial release
// ============================================================================
interface dsk_track_prefetch_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          trackLoad;
    logic [21:0]   trackStart;
    logic [15:0]   trackLength;
    logic [21:0]   dskReadAddr;
    logic          dskReadAck;
    logic          memoryLatch;
    logic [15:0]   memoryData;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          byteReady;
    logic          trackWrapped;
    logic [CW-1:0] fillLevel;

    modport slave (
        input  trackLoad, trackStart, trackLength,
        input  dskReadAck, memoryLatch, memoryData, byteReady,
        output dskReadAddr, byteValid, byteData, trackWrapped, fillLevel
    );

    modport master (
        output trackLoad, trackStart, trackLength,
        output dskReadAck, memoryLatch, memoryData, byteReady,
        input  dskReadAddr, byteValid, byteData, trackWrapped, fillLevel
    );

endinterface : dsk_track_prefetch_if
`default_nettype wire

// File: rtl/dsk_track_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dsk_word_fifo
// Brief    : Synchronous 16-bit word FIFO with flush; head is read directly.
// Revision : 1.0 - initial release
// ============================================================================
module dsk_word_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   _reset,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [15:0]            din,
    output logic      [$clog2(DEPTH):0] count,
    output logic      [15:0]            head
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = push && (r_count != (AW+1)'(DEPTH));
    assign w_doPop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!_reset || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (_reset && !flush && w_doPush) r_mem[r_wrPtr] <= din;
    end

    assign count = r_count;
    assign head  = r_mem[r_rdPtr];

endmodule : dsk_word_fifo
`default_nettype wire

// File: rtl/dsk_track_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : dsk_track_prefetch
// Brief    : Per-drive track prefetcher: slot word capture into a FIFO,
//            big-endian byte stream out.
// Revision : 1.0 - initial release
// ============================================================================
module dsk_track_prefetch
    import dsk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           _reset,
    dsk_track_prefetch_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    dskState_t     r_state;
    dskState_t     w_stateNext;
    logic [21:0]   r_base;
    logic [21:0]   r_addr;
    logic [15:0]   r_len;
    logic [15:0]   r_offset;
    logic          r_sel;
    logic          r_wrapped;
    logic [CW-1:0] w_count;
    logic [15:0]   w_head;
    logic [15:0]   w_offsetInc;
    logic          w_lastWord;
    logic          w_capture;
    logic          w_accept;
    logic          w_popWord;
    logic          w_valid;

    always_ff @(posedge clk) begin
        if (!_reset) r_state <= IDLE;
        else         r_state <= w_stateNext;
    end

    // trackLoad overrides any capture or pop landing in the same clk.
    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        if (bus.trackLoad) begin
            w_stateNext = ((bus.trackLength & 16'hFFFE) != 16'd0) ? RUN : IDLE;
        end else begin
            w_capture = (r_state == RUN) && bus.dskReadAck && bus.memoryLatch &&
                        (w_count < CW'(DEPTH));
            w_accept  = w_valid && bus.byteReady;
        end
    end

    assign w_valid     = (w_count != '0);
    assign w_popWord   = w_accept && r_sel;
    assign w_offsetInc = r_offset + 16'd2;
    assign w_lastWord  = (w_offsetInc == r_len);

    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_base    <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_offset  <= '0;
            r_sel     <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            if (bus.trackLoad) begin
                r_base   <= bus.trackStart & ~22'd1;
                r_addr   <= bus.trackStart & ~22'd1;
                r_len    <= bus.trackLength & 16'hFFFE;
                r_offset <= '0;
                r_sel    <= 1'b0;
            end else begin
                if (w_capture) begin
                    if (w_lastWord) begin
                        r_offset  <= '0;
                        r_addr    <= r_base;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_offset <= w_offsetInc;
                        r_addr   <= r_base + {6'd0, w_offsetInc};
                    end
                end
                if (w_accept) r_sel <= ~r_sel;
            end
        end
    end

    dsk_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        ._reset (_reset),
        .push   (w_capture),
        .pop    (w_popWord),
        .flush  (bus.trackLoad),
        .din    (bus.memoryData),
        .count  (w_count),
        .head   (w_head)
    );

    assign bus.dskReadAddr  = r_addr;
    assign bus.byteValid    = w_valid;
    assign bus.byteData     = !w_valid ? 8'h00 : (r_sel ? w_head[7:0] : w_head[15:8]);
    assign bus.trackWrapped = r_wrapped;
    assign bus.fillLevel    = w_count;

endmodule : dsk_track_prefetch
`default_nettype wire

// File: doc/dsk_track_prefetch.md
# dsk_track_prefetch

Floppy track prefetcher that sits upstream of the address controller's disk slots. It presents a disk-image word address, captures the RAM word returned in its granted extra-cycle slot, and buffers the data in a small word FIFO. It then serves the data as a big-endian byte stream to the IWM emulation. One instance exists per drive: the internal drive uses slot 0, the external drive uses slot 1.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in 16-bit words; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock (4× clk8).
- _reset  in  1  synchronous, active-low reset.
- trackLoad  in  1  single-clk pulse: start streaming a new track.
- trackStart  in  22  image-relative byte offset of the track; bit 0 ignored.
- trackLength  in  16  track length in bytes; bit 0 ignored.
- dskReadAddr  out  22  image-relative byte address of the next word; bit 0 always 0.
- dskReadAck  in  1  slot grant from the address controller; high for the whole granted busCycle.
- memoryLatch  in  1  RAM data valid strobe (busPhase 3).
- memoryData  in  16  RAM read data.
- byteValid  out  1  byteData is valid.
- byteData  out  8  current stream byte.
- byteReady  in  1  consumer accepts the byte when byteValid && byteReady.
- trackWrapped  out  1  single-clk pulse when the fetch pointer wraps to trackStart.
- fillLevel  out  $clog2(DEPTH)+1  number of words currently held in the FIFO.

## Operation
- States:
  - IDLE: reset state; no captures.
  - RUN: streaming.
- Transitions:
  - trackLoad with trackLength[15:1] ≠ 0 → RUN.
  - trackLoad with trackLength[15:1] = 0 → IDLE.
  - trackLoad in either state performs the load actions below.
- Load actions:
  - Flush the FIFO and clear the byte-select flag.
  - Latch base = trackStart & ~1 and len = trackLength & ~1.
  - Set offset = 0.
- dskReadAddr = base + offset, computed in 22 bits; overflow wraps modulo 2^22. It is registered and changes only on load or capture.
- Capture condition: state == RUN && dskReadAck && memoryLatch && fillLevel < DEPTH, evaluated in the same clk.
  - On capture, push memoryData.
  - If offset + 2 == len: set offset = 0 and pulse trackWrapped. Otherwise offset += 2.
- A granted slot that arrives while the FIFO is full is skipped. Address and offset are left unchanged, and the same word is fetched at the next grant.
- Byte side:
  - byteValid = fillLevel ≠ 0.
  - byteData = head[15:8] when the select flag is 0, head[7:0] when it is 1.
  - An accepted high byte sets the flag.
  - An accepted low byte pops the head word and clears the flag.
- Simultaneous push and pop: fullness is judged on the pre-pop count. A full FIFO never pushes, even when a pop occurs in the same clk. Non-full push plus pop leaves fillLevel unchanged.
- Precedence: trackLoad beats a capture and a pop in the same clk. That captured word is discarded and the pop is ignored.
- Reset mid-stream: same as power-up reset. In-flight slots are ignored.
- Reset values:
  - dskReadAddr = 0, byteValid = 0, byteData = 0, trackWrapped = 0, fillLevel = 0.
  - State IDLE, select flag = 0.

## Timing
- Capture-to-byteValid: 1 clk. FIFO write occurs on the memoryLatch clk, and byteValid is high on the next clk.
- dskReadAddr update: 1 clk after capture. It is therefore stable for the whole next grant (the minimum grant spacing is 16 clk8 = 64 clk).
- Pop-to-next-byte: combinational from the registered FIFO head. The flag and head update on the accepting clk.
- trackWrapped is asserted in the clk after the capture of the last word.
- Sustained throughput: 2 bytes per 64 clk per drive. The consumer sees underflow (byteValid low) if it reads faster than this.

## Structure
- Shared package dsk_pkg holds:
  - DSK_SLOT_INT = 2'd0, DSK_SLOT_EXT = 2'd1.
  - DSK_INT_BASE = 22'h100000, DSK_EXT_BASE = 22'h200000.
  - The state enum {IDLE, RUN}.
- Sub-module dsk_word_fifo: synchronous FIFO, 16 bits wide, DEPTH words.
  - Ports: push, pop, flush, count, head.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- The top level contains the state machine, offset/address arithmetic, and the byte-select logic.

## Test plan
- Reset, then trackLoad with start 0x1000 and length 8. Grant four slots returning 0xA1B2, 0xC3D4, 0xE5F6, 0x0718 with byteReady=1. Expected: bytes A1 B2 C3 D4 E5 F6 07 18; dskReadAddr goes 0x1000→0x1002→0x1004→0x1006→0x1000; trackWrapped pulses once after the 4th capture.
- Hold byteReady=0 and give 6 grants with DEPTH=4. Expected: fillLevel saturates at 4; grants 5 and 6 capture nothing; dskReadAddr stays at the 5th word's address; on release, bytes come out in order with no loss.
- Assert trackLoad (start 0x2000, length 6) in the same clk as a capture with the FIFO holding 2 words. Expected: fillLevel=0 next clk, dskReadAddr=0x2000, the captured word is discarded, byteValid=0.
- Issue trackLoad with length 1. Expected: state stays IDLE; grants produce no captures; byteValid stays 0.
- Full FIFO with a pop of the low byte coinciding with a capture. Expected: the capture is rejected, fillLevel goes 4→3, and dskReadAddr is unchanged.
- Apply _reset=0 mid-stream with 3 words buffered. Expected: next clk fillLevel=0, byteValid=0, dskReadAddr=0, trackWrapped=0; subsequent grants are ignored until trackLoad.
